mc_fp_controller: RTL and testbench
===================================

// Module: mc_fp_controller
// PURPOSE
//  Multicycle successor to the single-cycle decoder: Moore main FSM plus ALU/FPU decoder for the ARM-subset core.
//  Sequences fetch/decode/execute/writeback over several cycles sharing one ALU and one memory port.
//  Adds a 4-bit ALU op space, FP ops (Op=11) run on an external multi-cycle FPU via a start/done handshake,
//  and a sticky fault state for undefined instructions and FPU timeout.
// PARAMETERS
//  ALU_CTRL_W  4   ALUControl width; must be >=4
//  ENABLE_FP   1   1: Op=11 dispatches to FPU; 0: Op=11 -> FAULT
//  FP_TIMEOUT  16  max FPEXEC cycles waiting for fpu_done before FAULT; range 1..255
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-high
//  Op         in   2  instr[27:26], sampled from instruction register
//  Funct      in   6  instr[25:20]
//  Rd         in   4  instr[15:12]
//  fpu_done   in   1  FPU result valid, level
//  IRWrite    out  1  load instruction register
//  AdrSrc     out  1  0=PC, 1=ALU result as memory address
//  ALUSrcA    out  1  0=Rn, 1=PC
//  ALUSrcB    out  2  00=Rm, 01=ExtImm, 10=const 4
//  ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=FPU result
//  NextPC     out  1  unconditional PC write
//  Branch     out  1  conditional PC write (gated by condlogic)
//  RegW       out  1  register-file write intent (gated by condlogic)
//  MemW       out  1  memory write intent (gated by condlogic)
//  ImmSrc     out  2  = Op
//  RegSrc     out  2  {Op==01, Op==10}
//  ALUControl out  ALU_CTRL_W  ADD=0000 SUB=0001 AND=0010 ORR=0011 MUL=0100 FADD=1000 FMUL=1001
//  FlagW      out  2  [1]=NZ write, [0]=CV write
//  mov        out  1  ALU passes SrcB (MOV)
//  PCS        out  1  (Rd==15 & instr writes Rd) | Op==10
//  fpu_start  out  1  one-cycle FPU launch pulse
//  fp_busy    out  1  high while in FPEXEC
//  fault      out  1  high while in FAULT
// BEHAVIOUR
//  States: FETCH DECODE MEMADR MEMREAD MEMWB MEMWRITE EXECR EXECI ALUWB BRANCH FPEXEC FPWB FAULT.
//  Reset: state=FETCH, fp timeout counter=0, fpu_start=0; outputs immediately take FETCH values.
//  Transitions: FETCH->DECODE; MEMREAD->MEMWB->FETCH; MEMWRITE, BRANCH, FPWB ->FETCH; EXECR/EXECI->ALUWB->FETCH.
//  DECODE: Op=01->MEMADR; Op=00 & F[5]=0->EXECR; Op=00 & F[5]=1->EXECI; Op=10->BRANCH;
//   Op=11->FPEXEC if ENABLE_FP else FAULT; undefined cmd/FP op (see decoder) ->FAULT.
//  MEMADR: Funct[0]=1->MEMREAD, else MEMWRITE.
//  FPEXEC: fpu_done=1->FPWB; else counter+1; counter==FP_TIMEOUT-1 without done->FAULT; done wins same cycle.
//  FAULT: sticky; only reset exits. All enables (IRWrite,NextPC,Branch,RegW,MemW) 0 in FAULT.
//  Moore outputs (unlisted=0, ALUSrcB/ResultSrc=00):
//   FETCH: IRWrite=1 ALUSrcA=1 ALUSrcB=10 ResultSrc=10 NextPC=1 ALUControl=ADD. DECODE: ALUSrcA=1 ALUSrcB=10 ResultSrc=10.
//   MEMADR: ALUSrcB=01. MEMREAD: AdrSrc=1. MEMWB: ResultSrc=01 RegW=1. MEMWRITE: AdrSrc=1 MemW=1.
//   EXECR: ALUSrcB=00 decoded. EXECI: ALUSrcB=01 decoded. ALUWB: RegW=1 unless cmd is CMP.
//   BRANCH: ALUSrcB=01 ResultSrc=10 Branch=1. FPWB: ResultSrc=11 RegW=1.
//  Decoder (cmd=F[4:1]): 0100 ADD, 0010 SUB, 0000 AND (MUL if F[5]=0 i.e. register form), 1100 ORR,
//   1101 ADD+mov=1, 1010 CMP = SUB with RegW suppressed and FlagW forced 11; others undefined.
//   FP: cmd 0000 FADD, 0001 FMUL, others undefined. mov=0 for all non-1101.
//  FlagW only in EXECR/EXECI: [1]=F[0], [0]=F[0] & (ADD|SUB); FPWB: FlagW={F[0],0}; else 00.
//  ALUControl=ADD in all non-decoded states. fpu_start=1 exactly on first FPEXEC cycle; counter cleared on FPEXEC entry.
//  Async reset mid-FPEXEC: fpu_start/fp_busy drop immediately; no FPWB write occurs.
// TESTING
//  ADD R1,R2,R3 (Op=00,F=001000) -> FETCH,DECODE,EXECR,ALUWB; ALUControl=0000, RegW=1 only in ALUWB.
//  LDR (Op=01,F=011001) -> 5 cycles; AdrSrc=1 in MEMREAD, ResultSrc=01 RegW=1 in MEMWB; STR F[0]=0 -> MemW=1 in MEMWRITE.
//  FMUL S (Op=11,F=000011), fpu_done after 3 cycles -> fpu_start 1 cycle, fp_busy 3 cycles, FPWB ResultSrc=11 FlagW=10.
//  FADD, fpu_done never -> FAULT after FP_TIMEOUT=16 FPEXEC cycles; fault stays 1 until reset.
//  MOV F=111010 -> mov=1 ALUControl=0000; CMP F=010101 -> FlagW=11, RegW=0; cmd 1111 -> FAULT.
//  reset asserted in FPEXEC -> state FETCH, fpu_start=0, IRWrite=1 without clock edge.

Source files
------------

// File: rtl/mc_fp_controller.sv
// Multicycle main controller for the ARM-subset core: Moore FSM sequencing fetch/decode/execute/writeback,
// integer ALU decoder, FP dispatch to an external FPU with start/done handshake and timeout, sticky fault.
module mc_fp_controller #(
  parameter int ALU_CTRL_W = 4,
  parameter int ENABLE_FP  = 1,
  parameter int FP_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic                  fpu_done,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic                  NextPC,
  output logic                  Branch,
  output logic                  RegW,
  output logic                  MemW,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [1:0]            FlagW,
  output logic                  mov,
  output logic                  PCS,
  output logic                  fpu_start,
  output logic                  fp_busy,
  output logic                  fault
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_FPEXEC, S_FPWB, S_FAULT
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_ORR  = 4'b0011;
  localparam logic [3:0] ALU_MUL  = 4'b0100;
  localparam logic [3:0] ALU_FADD = 4'b1000;
  localparam logic [3:0] ALU_FMUL = 4'b1001;
  localparam logic [7:0] TMO_LAST = 8'(FP_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fpu_start_q, fpu_start_d;

  logic [3:0] cmd;
  logic       dp_ok, dp_cmp, dp_mov, dp_addsub, fp_ok, writes_rd;
  logic [3:0] dp_code, fp_code, alu_ctl;

  assign cmd = Funct[4:1];

  // Integer and FP command decode; shared by DECODE dispatch and execute-state outputs
  always_comb begin
    dp_ok     = 1'b1;
    dp_cmp    = 1'b0;
    dp_mov    = 1'b0;
    dp_addsub = 1'b0;
    dp_code   = ALU_ADD;
    case (cmd)
      4'b0100: dp_addsub = 1'b1;
      4'b0010: begin dp_code = ALU_SUB; dp_addsub = 1'b1; end
      4'b0000: dp_code = Funct[5] ? ALU_AND : ALU_MUL;
      4'b1100: dp_code = ALU_ORR;
      4'b1101: dp_mov = 1'b1;
      4'b1010: begin dp_code = ALU_SUB; dp_addsub = 1'b1; dp_cmp = 1'b1; end
      default: dp_ok = 1'b0;
    endcase
    fp_ok   = (cmd == 4'b0000) || (cmd == 4'b0001);
    fp_code = (cmd == 4'b0001) ? ALU_FMUL : ALU_FADD;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fpu_start_d = 1'b0;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = !dp_ok ? S_FAULT : (Funct[5] ? S_EXECI : S_EXECR);
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = ((ENABLE_FP != 0) && fp_ok) ? S_FPEXEC : S_FAULT;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_FPEXEC: begin
        // A done seen on the last allowed cycle still completes normally
        if (fpu_done)               state_d = S_FPWB;
        else if (cnt_q == TMO_LAST) state_d = S_FAULT;
        else                        cnt_d = cnt_q + 8'd1;
      end
      S_FPWB:     state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
    if ((state_d == S_FPEXEC) && (state_q != S_FPEXEC)) begin
      fpu_start_d = 1'b1;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      fpu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fpu_start_q <= fpu_start_d;
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    Branch    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    FlagW     = 2'b00;
    mov       = 1'b0;
    alu_ctl   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; NextPC = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; RegW = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemW = 1'b1; end
      S_EXECR, S_EXECI: begin
        ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_ctl = dp_code;
        mov     = dp_mov;
        FlagW   = dp_cmp ? 2'b11 : {Funct[0], Funct[0] & dp_addsub};
      end
      S_ALUWB:    RegW = !dp_cmp;
      S_BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; Branch = 1'b1; end
      S_FPEXEC:   alu_ctl = fp_code;
      S_FPWB:     begin ResultSrc = 2'b11; RegW = 1'b1; FlagW = {Funct[0], 1'b0}; end
      default:    ;
    endcase
  end

  assign writes_rd  = ((Op == 2'b00) && (cmd != 4'b1010)) || ((Op == 2'b01) && Funct[0]) || (Op == 2'b11);
  assign PCS        = ((Rd == 4'd15) && writes_rd) || (Op == 2'b10);
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign ALUControl = ALU_CTRL_W'(alu_ctl);
  assign fpu_start  = fpu_start_q;
  assign fp_busy    = (state_q == S_FPEXEC);
  assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_mc_fp_controller.sv
// Scoreboard bench for mc_fp_controller: per-cycle expected output vectors queued per instruction.
module tb_mc_fp_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       fpu_done;
  logic       IRWrite, AdrSrc, ALUSrcA, NextPC, Branch, RegW, MemW, mov, PCS;
  logic       fpu_start, fp_busy, fault;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
  logic [3:0] ALUControl;

  mc_fp_controller #(.ALU_CTRL_W(4), .ENABLE_FP(1), .FP_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .fpu_done(fpu_done),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .Branch(Branch), .RegW(RegW), .MemW(MemW),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW), .mov(mov),
    .PCS(PCS), .fpu_start(fpu_start), .fp_busy(fp_busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [20:0] v;
    logic [20:0] m;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [20:0] obs;
  logic [20:0] V_FETCH, V_DECODE, V_FAULT;
  localparam logic [20:0] M_ALL   = 21'h1FFFFF;
  localparam logic [20:0] M_NOALU = 21'h1FFFFF & ~21'h0003C0;

  assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, Branch, RegW, MemW,
                ALUControl, FlagW, mov, fpu_start, fp_busy, fault};

  function automatic logic [20:0] mk(input logic irw, input logic adr, input logic sa,
      input logic [1:0] srcb, input logic [1:0] rs, input logic npc, input logic br,
      input logic rw, input logic mw, input logic [3:0] alu, input logic [1:0] fw,
      input logic mv, input logic st, input logic bz, input logic ft);
    return {irw, adr, sa, srcb, rs, npc, br, rw, mw, alu, fw, mv, st, bz, ft};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input logic [20:0] v);
    sb.push_back('{v: v, m: M_ALL});
  endtask

  task automatic push_fp(input logic [20:0] v);
    sb.push_back('{v: v, m: M_NOALU});
  endtask

  // Compare current outputs against each queued entry, then advance one clock
  task automatic drain(input string tag, input int done_at);
    exp_t e;
    int   i;
    i = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      fpu_done = (i == done_at);
      check($sformatf("%s[%0d]", tag, i), 32'(obs & e.m), 32'(e.v & e.m));
      @(posedge clk);
      #1;
      i++;
    end
    fpu_done = 1'b0;
  endtask

  task automatic load(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    Op = op;
    Funct = f;
    Rd = rd;
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check(tag, 32'(obs), 32'(V_FETCH));
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    V_FETCH  = mk(1,0,1,2'b10,2'b10,1,0,0,0,4'h0,2'b00,0,0,0,0);
    V_DECODE = mk(0,0,1,2'b10,2'b10,0,0,0,0,4'h0,2'b00,0,0,0,0);
    V_FAULT  = mk(0,0,0,2'b00,2'b00,0,0,0,0,4'h0,2'b00,0,0,0,1);
    reset = 1'b1;
    fpu_done = 1'b0;
    load(2'b00, 6'b001000, 4'd1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(obs), 32'(V_FETCH));
    reset = 1'b0;

    // ADD R1,R2,R3
    load(2'b00, 6'b001000, 4'd15);
    #1;
    check("pcs_add_r15", 32'(PCS), 32'd1);
    push(V_FETCH); push(V_DECODE);
    push(mk(0,0,0,2'b00,2'b00,0,0,0,0,4'b0000,2'b00,0,0,0,0));
    push(mk(0,0,0,2'b00,2'b00,0,0,1,0,4'b0000,2'b00,0,0,0,0));
    drain("add", -1);

    // LDR
    load(2'b01, 6'b011001, 4'd15);
    #1;
    check("pcs_ldr_r15", 32'(PCS), 32'd1);
    push(V_FETCH); push(V_DECODE);
    push(mk(0,0,0,2'b01,2'b00,0,0,0,0,4'h0,2'b00,0,0,0,0));
    push(mk(0,1,0,2'b00,2'b00,0,0,0,0,4'h0,2'b00,0,0,0,0));
    push(mk(0,0,0,2'b00,2'b01,0,0,1,0,4'h0,2'b00,0,0,0,0));
    drain("ldr", -1);

    // STR
    load(2'b01, 6'b011000, 4'd15);
    #1;
    check("pcs_str_r15", 32'(PCS), 32'd0);
    check("immsrc_regsrc_str", 32'({ImmSrc, RegSrc}), 32'b0110);
    push(V_FETCH); push(V_DECODE);
    push(mk(0,0,0,2'b01,2'b00,0,0,0,0,4'h0,2'b00,0,0,0,0));
    push(mk(0,1,0,2'b00,2'b00,0,0,0,1,4'h0,2'b00,0,0,0,0));
    drain("str", -1);

    // Branch
    load(2'b10, 6'b000000, 4'd0);
    #1;
    check("pcs_branch", 32'(PCS), 32'd1);
    check("immsrc_regsrc_b", 32'({ImmSrc, RegSrc}), 32'b1001);
    push(V_FETCH); push(V_DECODE);
    push(mk(0,0,0,2'b01,2'b10,0,1,0,0,4'h0,2'b00,0,0,0,0));
    drain("branch", -1);

    // MUL (register-form AND slot)
    load(2'b00, 6'b000000, 4'd2);
    push(V_FETCH); push(V_DECODE);
    push(mk(0,0,0,2'b00,2'b00,0,0,0,0,4'b0100,2'b00,0,0,0,0));
    push(mk(0,0,0,2'b00,2'b00,0,0,1,0,4'b0000,2'b00,0,0,0,0));
    drain("mul", -1);

    // ORRS immediate: ORR does not write CV
    load(2'b00, 6'b111001, 4'd3);
    push(V_FETCH); push(V_DECODE);
    push(mk(0,0,0,2'b01,2'b00,0,0,0,0,4'b0011,2'b10,0,0,0,0));
    push(mk(0,0,0,2'b00,2'b00,0,0,1,0,4'b0000,2'b00,0,0,0,0));
    drain("orrs_imm", -1);

    // SUBS immediate
    load(2'b00, 6'b100101, 4'd4);
    push(V_FETCH); push(V_DECODE);
    push(mk(0,0,0,2'b01,2'b00,0,0,0,0,4'b0001,2'b11,0,0,0,0));
    push(mk(0,0,0,2'b00,2'b00,0,0,1,0,4'b0000,2'b00,0,0,0,0));
    drain("subs_imm", -1);

    // MOV immediate
    load(2'b00, 6'b111010, 4'd5);
    push(V_FETCH); push(V_DECODE);
    push(mk(0,0,0,2'b01,2'b00,0,0,0,0,4'b0000,2'b00,1,0,0,0));
    push(mk(0,0,0,2'b00,2'b00,0,0,1,0,4'b0000,2'b00,0,0,0,0));
    drain("mov", -1);

    // CMP: no register write, flags forced
    load(2'b00, 6'b010101, 4'd15);
    #1;
    check("pcs_cmp_r15", 32'(PCS), 32'd0);
    push(V_FETCH); push(V_DECODE);
    push(mk(0,0,0,2'b00,2'b00,0,0,0,0,4'b0001,2'b11,0,0,0,0));
    push(mk(0,0,0,2'b00,2'b00,0,0,0,0,4'b0000,2'b00,0,0,0,0));
    drain("cmp", -1);

    // FMUL with done on third FPEXEC cycle
    load(2'b11, 6'b000011, 4'd6);
    push(V_FETCH); push(V_DECODE);
    push_fp(mk(0,0,0,2'b00,2'b00,0,0,0,0,4'h0,2'b00,0,1,1,0));
    push_fp(mk(0,0,0,2'b00,2'b00,0,0,0,0,4'h0,2'b00,0,0,1,0));
    push_fp(mk(0,0,0,2'b00,2'b00,0,0,0,0,4'h0,2'b00,0,0,1,0));
    push(mk(0,0,0,2'b00,2'b11,0,0,1,0,4'h0,2'b10,0,0,0,0));
    drain("fmul", 4);

    // Undefined integer command -> sticky fault
    load(2'b00, 6'b011110, 4'd7);
    push(V_FETCH); push(V_DECODE);
    push(V_FAULT); push(V_FAULT); push(V_FAULT);
    drain("undef", -1);
    pulse_reset("undef_reset");

    // FADD with no done -> fault after 16 FPEXEC cycles
    load(2'b11, 6'b000000, 4'd8);
    push(V_FETCH); push(V_DECODE);
    for (int k = 0; k < 16; k++)
      push_fp(mk(0,0,0,2'b00,2'b00,0,0,0,0,4'h0,2'b00,0,(k == 0),1,0));
    for (int k = 0; k < 4; k++) push(V_FAULT);
    drain("fadd_tmo", -1);
    fpu_done = 1'b1;
    @(posedge clk);
    #1;
    check("fault_sticky", 32'(obs), 32'(V_FAULT));
    fpu_done = 1'b0;
    pulse_reset("tmo_reset");

    // Async reset during the first FPEXEC cycle
    load(2'b11, 6'b000011, 4'd9);
    push(V_FETCH); push(V_DECODE);
    drain("fp_pre", -1);
    check("fp_first", 32'(obs & M_NOALU),
          32'(mk(0,0,0,2'b00,2'b00,0,0,0,0,4'h0,2'b00,0,1,1,0) & M_NOALU));
    fpu_done = 1'b1;
    pulse_reset("fp_async_reset");
    fpu_done = 1'b0;
    push(V_FETCH); push(V_DECODE);
    push_fp(mk(0,0,0,2'b00,2'b00,0,0,0,0,4'h0,2'b00,0,1,1,0));
    push(mk(0,0,0,2'b00,2'b11,0,0,1,0,4'h0,2'b10,0,0,0,0));
    push(V_FETCH);
    drain("fp_after_reset", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
